// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - 7-segment constants, nibble decoder and debouncer state type
package seg7_pkg;

    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        ARMING,
        PRESSED,
        RELEASING
    } deb_state_t;

    // Active-low, bit 0 = segment a ... bit 6 = segment g
    function automatic logic [6:0] seg7_encode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - 2-flop key synchroniser and debounce FSM, one step pulse per press
module key_debouncer
    import seg7_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_key,
    output logic o_step
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             r_sync1;
    logic             r_sync2;
    deb_state_t       r_state;
    deb_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_step      = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_sync2) begin
                    w_state_nxt = ARMING;
                    w_cnt_nxt   = '0;
                end
            end
            ARMING: begin
                if (!r_sync2) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            PRESSED: begin
                o_step      = 1'b1;
                w_state_nxt = RELEASING;
                w_cnt_nxt   = '0;
            end
            RELEASING: begin
                // Any high sample restarts the quiet-time count
                if (r_sync2) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/hex_display_pager.sv
// rtl/hex_display_pager.sv - channel snapshot paged across 7-segment digits on debounced key steps
// Optional auto-scroll: define HEX_PAGER_AUTO_SCROLL_EN.
module hex_display_pager
    import seg7_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int NUM_CH       = 4,
    parameter int NUM_DIGITS   = 6,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int SCROLL_CYC   = 50000000,
    localparam int NUM_PAGES   = (DATA_W + 4*NUM_DIGITS - 1) / (4*NUM_DIGITS),
    localparam int CH_W        = $clog2(NUM_CH),
    localparam int PG_W        = $clog2(NUM_PAGES) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [CH_W-1:0]         ch_sel,
    input  logic                    page_key,
    input  logic                    freeze,
    output logic [NUM_DIGITS*7-1:0] hex,
    output logic [PG_W-1:0]         page_idx,
    output logic [CH_W-1:0]         ch_idx
);

    if (DATA_W % 4 != 0 || NUM_CH < 2 || SCROLL_CYC < 1) begin : g_bad_cfg
        $error("hex_display_pager: invalid parameter set");
    end

    logic [CH_W-1:0]         r_ch_idx;
    logic [PG_W-1:0]         r_page;
    logic [DATA_W-1:0]       r_snap;
    logic [NUM_DIGITS*7-1:0] r_hex;
    logic [CH_W-1:0]         w_sel_eff;
    logic [DATA_W-1:0]       w_ch_word;
    logic                    w_ch_change;
    logic                    w_key_step;
    logic                    w_advance;

    key_debouncer #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_key_debouncer (
        .clk   (clk),
        .reset (reset),
        .i_key (page_key),
        .o_step(w_key_step)
    );

    assign w_sel_eff   = ({1'b0, ch_sel} < (CH_W+1)'(NUM_CH)) ? ch_sel : '0;
    assign w_ch_word   = ch_data[w_sel_eff*DATA_W +: DATA_W];
    assign w_ch_change = (r_ch_idx != w_sel_eff);

`ifdef HEX_PAGER_AUTO_SCROLL_EN
    localparam int SC_W = (SCROLL_CYC > 1) ? $clog2(SCROLL_CYC) : 1;

    logic [SC_W-1:0] r_scroll_cnt;
    logic            w_scroll_tick;

    assign w_scroll_tick = !freeze && (r_scroll_cnt == SC_W'(SCROLL_CYC - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scroll_cnt <= '0;
        end else if (w_key_step || w_scroll_tick) begin
            r_scroll_cnt <= '0;
        end else if (!freeze) begin
            r_scroll_cnt <= r_scroll_cnt + 1'b1;
        end
    end

    assign w_advance = w_key_step | w_scroll_tick;
`else
    assign w_advance = w_key_step;
`endif

    // Nibbles past the end of the word show blank digits on the last page
    function automatic logic [NUM_DIGITS*7-1:0] page_segments(
        input logic [DATA_W-1:0] snap,
        input logic [PG_W-1:0]   page
    );
        logic [NUM_DIGITS*7-1:0] segs;
        int nib;
        segs = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            nib = int'(page) * NUM_DIGITS + d;
            if (nib < DATA_W / 4) begin
                segs[d*7 +: 7] = seg7_encode(4'(snap >> (4 * nib)));
            end else begin
                segs[d*7 +: 7] = SEG_BLANK;
            end
        end
        return segs;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ch_idx <= '0;
            r_page   <= '0;
            r_snap   <= '0;
            r_hex    <= {NUM_DIGITS{SEG_ZERO}};
        end else begin
            r_ch_idx <= w_sel_eff;
            // A channel switch restarts paging and outranks a same-cycle step
            if (w_ch_change) begin
                r_page <= '0;
            end else if (w_advance) begin
                r_page <= (r_page == PG_W'(NUM_PAGES - 1)) ? '0 : r_page + 1'b1;
            end
            if (!freeze || w_ch_change) begin
                r_snap <= w_ch_word;
            end
            r_hex <= page_segments(r_snap, r_page);
        end
    end

    assign hex      = r_hex;
    assign page_idx = r_page;
    assign ch_idx   = r_ch_idx;

endmodule

// File: tb/tb_hex_display_pager.sv
// tb/tb_hex_display_pager.sv - directed and randomized checks of hex_display_pager against a reference model
module tb_hex_display_pager;

    localparam int DATA_W = 32;
    localparam int NUM_CH = 4;
    localparam int NDIG   = 6;
    localparam int DEB    = 4;
    localparam int NPAGES = (DATA_W + 4*NDIG - 1) / (4*NDIG);

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [1:0]               ch_sel;
    logic                     page_key;
    logic                     freeze;
    logic [NDIG*7-1:0]        hex;
    logic [1:0]               page_idx;
    logic [1:0]               ch_idx;

    int n_cmp = 0;
    int n_bad = 0;
    int m_pg  = 0;
    int m_ch  = 0;
    logic [31:0] m_snap;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    always #5 clk = ~clk;

    hex_display_pager #(
        .DATA_W(DATA_W), .NUM_CH(NUM_CH), .NUM_DIGITS(NDIG),
        .DEBOUNCE_CYC(DEB), .SCROLL_CYC(8)
    ) u_dut (
        .clk(clk), .reset(reset), .ch_data(ch_data), .ch_sel(ch_sel),
        .page_key(page_key), .freeze(freeze), .hex(hex),
        .page_idx(page_idx), .ch_idx(ch_idx)
    );

    function automatic logic [NDIG*7-1:0] exp_hex(input logic [31:0] v, input int page);
        logic [NDIG*7-1:0] r;
        for (int d = 0; d < NDIG; d++) begin
            int n = page * NDIG + d;
            r[d*7 +: 7] = (n < DATA_W / 4) ? seg_tab[(v >> (4 * n)) & 32'hF] : 7'h7F;
        end
        return r;
    endfunction

    function automatic logic [31:0] cur_word();
        return ch_data[ch_sel*32 +: 32];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int hold, input string tag);
        int old = m_pg;
        int nxt = (m_pg + 1) % NPAGES;
        int last = (hold > DEB + 5) ? hold : DEB + 5;
        page_key = 1'b1;
        for (int i = 1; i <= last; i++) begin
            tick();
            if (i == hold) page_key = 1'b0;
            if (i == DEB + 3) check({tag, "_page_before"}, page_idx, old);
            if (i == DEB + 4) check({tag, "_page_after"}, page_idx, nxt);
        end
        page_key = 1'b0;
        repeat (DEB + 6) tick();
        m_pg = nxt;
        check({tag, "_page_settled"}, page_idx, m_pg);
        check({tag, "_hex"}, hex, exp_hex(cur_word(), m_pg));
    endtask

    task automatic step_with_change(input logic [1:0] new_sel, input string tag);
        page_key = 1'b1;
        repeat (DEB + 3) tick();
        ch_sel = new_sel;
        tick();
        m_pg = 0;
        check({tag, "_page"}, page_idx, 0);
        check({tag, "_ch"}, ch_idx, new_sel);
        tick();
        check({tag, "_hex"}, hex, exp_hex(cur_word(), 0));
        page_key = 1'b0;
        repeat (DEB + 6) tick();
        check({tag, "_page_settled"}, page_idx, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        page_key = 1'b0;
        freeze   = 1'b0;
        ch_sel   = 2'd1;
        ch_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
        ch_data[32 +: 32] = 32'h1234_5678;
        #2 reset = 1'b1;
        #1;
        check("rst_hex_async", hex, {NDIG{7'h40}});
        check("rst_page", page_idx, 0);
        check("rst_ch", ch_idx, 0);
        repeat (3) tick();
        check("rst_hold_hex", hex, {NDIG{7'h40}});
        check("rst_hold_ch", ch_idx, 0);
        reset = 1'b0;
        tick();
        tick();
        check("post_rst_hex", hex, exp_hex(32'h1234_5678, 0));
        check("post_rst_page", page_idx, 0);
        check("post_rst_ch", ch_idx, 1);

        press(DEB + 1 + $urandom_range(0, 6), "press1");
        check("page1_digits", hex, {{4{7'h7F}}, seg_tab[1], seg_tab[2]});
        press(3 * DEB + 10, "press_long");

        for (int i = 0; i < 20; i++) begin
            page_key = ((i / 2) % 2 == 0);
            tick();
            check("bounce_page", page_idx, m_pg);
        end
        page_key = 1'b0;
        repeat (DEB + 6) tick();
        check("bounce_settled", page_idx, m_pg);

        freeze = 1'b1;
        tick();
        ch_data[32 +: 32] = 32'hDEAD_BEEF;
        repeat (4) tick();
        check("freeze_hold", hex, exp_hex(32'h1234_5678, m_pg));
        freeze = 1'b0;
        tick();
        check("unfreeze_1cyc", hex, exp_hex(32'h1234_5678, m_pg));
        tick();
        check("unfreeze_2cyc", hex, exp_hex(32'hDEAD_BEEF, m_pg));

        press(DEB + 2, "press3");
        step_with_change(2'd2, "simul_p1");
        step_with_change(2'd3, "simul_p0");

        press(DEB + 1 + $urandom_range(0, 4), "press4");
        m_snap = cur_word();
        m_ch   = ch_sel;
        for (int i = 0; i < 40; i++) begin
            ch_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) ch_sel = 2'($urandom_range(0, 3));
            freeze = ($urandom_range(0, 2) == 0);
            tick();
            check("rand_hex", hex, exp_hex(m_snap, m_pg));
            if (int'(ch_sel) != m_ch) m_pg = 0;
            if (!freeze || int'(ch_sel) != m_ch) m_snap = cur_word();
            m_ch = ch_sel;
            check("rand_page", page_idx, m_pg);
            check("rand_ch", ch_idx, m_ch);
        end
        freeze = 1'b0;

        ch_sel = 2'd0;
        repeat (3) tick();
        page_key = 1'b1;
        repeat (DEB + 1) tick();
        reset = 1'b1;
        #2;
        check("midpress_rst_hex", hex, {NDIG{7'h40}});
        check("midpress_rst_page", page_idx, 0);
        page_key = 1'b0;
        tick();
        reset = 1'b0;
        repeat (DEB + 8) tick();
        check("midpress_no_step", page_idx, 0);
        check("midpress_hex", hex, exp_hex(cur_word(), 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
